// File: rtl/lu_pkg.sv
// Shared definitions for the 16-bit logic unit and its command sequencer.
package lu_pkg;

    localparam int LU_DATA_W = 16;

    localparam logic [2:0] LU_AND  = 3'b000;
    localparam logic [2:0] LU_OR   = 3'b001;
    localparam logic [2:0] LU_XOR  = 3'b010;
    localparam logic [2:0] LU_XNOR = 3'b011;
    localparam logic [2:0] LU_NAND = 3'b100;
    localparam logic [2:0] LU_NOR  = 3'b101;
    localparam logic [2:0] LU_NOTA = 3'b110;
    localparam logic [2:0] LU_TWOS = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } lu_seq_state_t;

endpackage

// File: rtl/lu_seq_top.sv
// Integration wrapper: lu_sequencer driving the mux_8 logic unit.
module lu_seq_top
    import lu_pkg::*;
#(
    parameter int DATA_W        = LU_DATA_W,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [2:0]        rsp_op,
    output logic              rsp_zero,
    output logic              rsp_neg,
    output logic              busy,
    output logic [15:0]       op_count
);

    logic [DATA_W-1:0] lu_a_s;
    logic [DATA_W-1:0] lu_b_s;
    logic              lu_s1_s;
    logic              lu_s2_s;
    logic              lu_s3_s;
    logic [DATA_W-1:0] lu_out_s;

    lu_sequencer #(
        .DATA_W        (DATA_W),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .lu_a      (lu_a_s),
        .lu_b      (lu_b_s),
        .lu_s1     (lu_s1_s),
        .lu_s2     (lu_s2_s),
        .lu_s3     (lu_s3_s),
        .lu_out    (lu_out_s),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_op    (rsp_op),
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg),
        .busy      (busy),
        .op_count  (op_count)
    );

    mux_8 #(
        .DATA_W (DATA_W)
    ) u_lu (
        .a  (lu_a_s),
        .b  (lu_b_s),
        .s1 (lu_s1_s),
        .s2 (lu_s2_s),
        .s3 (lu_s3_s),
        .y  (lu_out_s)
    );

endmodule

// File: rtl/mux_8.sv
// Combinational 16-bit logic unit; select {s1,s2,s3} picks one of eight functions of a/b.
module mux_8
    import lu_pkg::*;
#(
    parameter int DATA_W = LU_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              s1,
    input  logic              s2,
    input  logic              s3,
    output logic [DATA_W-1:0] y
);

    // Function select decode
    always_comb begin
        y = {DATA_W{1'b0}};
        case ({s1, s2, s3})
            LU_AND:  y = a & b;
            LU_OR:   y = a | b;
            LU_XOR:  y = a ^ b;
            LU_XNOR: y = ~(a ^ b);
            LU_NAND: y = ~(a & b);
            LU_NOR:  y = ~(a | b);
            LU_NOTA: y = ~a;
            LU_TWOS: y = {DATA_W{1'b0}} - a;
            default: y = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/lu_sequencer.sv
// Command-side controller for mux_8: registers operands/select, waits SETTLE_CYCLES, captures result.
// Optional result flags (rsp_zero/rsp_neg) are built only when LU_SEQ_FLAGS_EN is defined.
module lu_sequencer
    import lu_pkg::*;
#(
    parameter int DATA_W        = LU_DATA_W,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [DATA_W-1:0] lu_a,
    output logic [DATA_W-1:0] lu_b,
    output logic              lu_s1,
    output logic              lu_s2,
    output logic              lu_s3,
    input  logic [DATA_W-1:0] lu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [2:0]        rsp_op,
    output logic              rsp_zero,
    output logic              rsp_neg,
    output logic              busy,
    output logic [15:0]       op_count
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    lu_seq_state_t     state_r;
    logic [3:0]        cnt_r;
    logic [DATA_W-1:0] lu_a_r;
    logic [DATA_W-1:0] lu_b_r;
    logic [2:0]        sel_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic [2:0]        rsp_op_r;
    logic [15:0]       op_count_r;

    logic ready_s;
    logic accept_s;
    logic capture_s;
    logic rsp_hs_s;

    // Ready is combinational so a result release and the next accept can share one edge
    always_comb begin
        ready_s = 1'b0;
        if (rst) begin
            ready_s = 1'b0;
        end else if (state_r == IDLE) begin
            ready_s = 1'b1;
        end else if (state_r == HOLD) begin
            ready_s = rsp_ready;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign accept_s  = cmd_valid && ready_s;
    assign capture_s = (state_r == DRIVE) && (cnt_r == 4'd0);
    assign rsp_hs_s  = (state_r == HOLD) && rsp_valid_r && rsp_ready;

    // Main FSM with response-valid and completed-handshake count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            op_count_r  <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (capture_s) begin
                        rsp_valid_r <= 1'b1;
                        state_r     <= HOLD;
                    end
                end
                HOLD: begin
                    if (rsp_hs_s) begin
                        op_count_r <= op_count_r + 16'd1;
                        // A chained accept keeps rsp_valid high so results stream without a bubble
                        if (accept_s) begin
                            state_r <= DRIVE;
                        end else begin
                            rsp_valid_r <= 1'b0;
                            state_r     <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Operand/select registers change only when a command is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_a_r <= {DATA_W{1'b0}};
            lu_b_r <= {DATA_W{1'b0}};
            sel_r  <= 3'b000;
        end else if (accept_s) begin
            lu_a_r <= cmd_a;
            lu_b_r <= cmd_b;
            sel_r  <= cmd_op;
        end
    end

    // Settle counter: loaded on accept, counts down while driving
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (accept_s) begin
            cnt_r <= SETTLE_LOAD;
        end else if ((state_r == DRIVE) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Result capture: lu_out is sampled only at the DRIVE-exit edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data_r <= {DATA_W{1'b0}};
            rsp_op_r   <= 3'b000;
        end else if (capture_s) begin
            rsp_data_r <= lu_out;
            rsp_op_r   <= sel_r;
        end
    end

`ifdef LU_SEQ_FLAGS_EN
    logic rsp_zero_r;
    logic rsp_neg_r;

    // Result flags captured alongside rsp_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_zero_r <= 1'b0;
            rsp_neg_r  <= 1'b0;
        end else if (capture_s) begin
            rsp_zero_r <= (lu_out == {DATA_W{1'b0}});
            rsp_neg_r  <= lu_out[DATA_W-1];
        end
    end

    assign rsp_zero = rsp_zero_r;
    assign rsp_neg  = rsp_neg_r;
`else
    assign rsp_zero = 1'b0;
    assign rsp_neg  = 1'b0;
`endif

    assign cmd_ready = ready_s;
    assign lu_a      = lu_a_r;
    assign lu_b      = lu_b_r;
    assign lu_s1     = sel_r[2];
    assign lu_s2     = sel_r[1];
    assign lu_s3     = sel_r[0];
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_op    = rsp_op_r;
    assign busy      = (state_r != IDLE);
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_lu_sequencer.sv
// Bench for lu_sequencer: two instances (settle 1 and 3) share stimulus, each against a transaction model.
module tb_lu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmd_valid = 1'b0;
    logic rsp_ready = 1'b0;
    logic [2:0]  cmd_op = 3'b000;
    logic [15:0] cmd_a = 16'h0000;
    logic [15:0] cmd_b = 16'h0000;

    logic [1:0]  cmd_ready, rsp_valid, lu_s1, lu_s2, lu_s3, rsp_zero, rsp_neg, busy;
    logic [1:0]  glitch = 2'b00;
    logic [15:0] glitch_val = 16'h0000;
    logic [15:0] lu_a [2];
    logic [15:0] lu_b [2];
    logic [15:0] lu_out [2];
    logic [15:0] rsp_data [2];
    logic [15:0] op_count [2];
    logic [2:0]  rsp_op [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance
    int          m_remain [2];
    bit          m_hold [2];
    bit          m_valid [2];
    bit          m_zero [2];
    bit          m_neg [2];
    logic [15:0] m_a [2];
    logic [15:0] m_b [2];
    logic [15:0] m_data [2];
    logic [15:0] m_count [2];
    logic [2:0]  m_op [2];
    logic [2:0]  m_rop [2];

    always #5 clk = ~clk;

    function automatic logic [15:0] lu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a ^ b);
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~a;
            default: return 16'd0 - a;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lu_sequencer #(
            .DATA_W        (16),
            .SETTLE_CYCLES ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid),
            .cmd_ready (cmd_ready[g]),
            .cmd_op    (cmd_op),
            .cmd_a     (cmd_a),
            .cmd_b     (cmd_b),
            .lu_a      (lu_a[g]),
            .lu_b      (lu_b[g]),
            .lu_s1     (lu_s1[g]),
            .lu_s2     (lu_s2[g]),
            .lu_s3     (lu_s3[g]),
            .lu_out    (lu_out[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready),
            .rsp_data  (rsp_data[g]),
            .rsp_op    (rsp_op[g]),
            .rsp_zero  (rsp_zero[g]),
            .rsp_neg   (rsp_neg[g]),
            .busy      (busy[g]),
            .op_count  (op_count[g])
        );
        assign lu_out[g] = glitch[g] ? glitch_val : lu_ref({lu_s1[g], lu_s2[g], lu_s3[g]}, lu_a[g], lu_b[g]);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            m_remain[g] = 0;  m_hold[g] = 1'b0; m_valid[g] = 1'b0;
            m_zero[g] = 1'b0; m_neg[g] = 1'b0;
            m_a[g] = 16'h0;   m_b[g] = 16'h0;   m_data[g] = 16'h0; m_count[g] = 16'h0;
            m_op[g] = 3'b000; m_rop[g] = 3'b000;
        end
    endtask

    task automatic model_edge(input int g, input bit rdy);
        bit acc;
        logic [15:0] res;
        acc = cmd_valid && rdy;
        if (m_hold[g] && rsp_ready) begin
            m_count[g] = m_count[g] + 16'd1;
            m_hold[g]  = 1'b0;
            if (!acc) m_valid[g] = 1'b0;
        end
        if (m_remain[g] > 0) begin
            m_remain[g]--;
            if (m_remain[g] == 0) begin
                res = lu_ref(m_op[g], m_a[g], m_b[g]);
                m_data[g]  = res;
                m_rop[g]   = m_op[g];
                m_hold[g]  = 1'b1;
                m_valid[g] = 1'b1;
`ifdef LU_SEQ_FLAGS_EN
                m_zero[g] = (res == 16'h0);
                m_neg[g]  = res[15];
`endif
            end
        end
        if (acc) begin
            m_a[g] = cmd_a;
            m_b[g] = cmd_b;
            m_op[g] = cmd_op;
            m_remain[g] = (g == 0) ? 1 : 3;
        end
    endtask

    task automatic check_regs(input int g);
        check_eq($sformatf("rsp_valid%0d", g), 32'(rsp_valid[g]), 32'(m_valid[g]));
        check_eq($sformatf("rsp_data%0d", g), 32'(rsp_data[g]), 32'(m_data[g]));
        check_eq($sformatf("rsp_op%0d", g), 32'(rsp_op[g]), 32'(m_rop[g]));
        check_eq($sformatf("lu_a%0d", g), 32'(lu_a[g]), 32'(m_a[g]));
        check_eq($sformatf("lu_b%0d", g), 32'(lu_b[g]), 32'(m_b[g]));
        check_eq($sformatf("lu_s%0d", g), 32'({lu_s1[g], lu_s2[g], lu_s3[g]}), 32'(m_op[g]));
        check_eq($sformatf("op_count%0d", g), 32'(op_count[g]), 32'(m_count[g]));
        check_eq($sformatf("busy%0d", g), 32'(busy[g]), 32'((m_remain[g] > 0) || m_hold[g]));
        check_eq($sformatf("zero%0d", g), 32'(rsp_zero[g]), 32'(m_zero[g]));
        check_eq($sformatf("neg%0d", g), 32'(rsp_neg[g]), 32'(m_neg[g]));
    endtask

    // One clock: check ready before the edge, advance model, check registers after the edge
    task automatic step();
        bit rdy [2];
        #1;
        for (int g = 0; g < 2; g++) begin
            rdy[g] = ((m_remain[g] == 0) && !m_hold[g]) || (m_hold[g] && rsp_ready);
            check_eq($sformatf("cmd_ready%0d", g), 32'(cmd_ready[g]), 32'(rdy[g]));
            glitch[g] = (m_remain[g] != 1) && ($urandom_range(0, 1) == 1);
        end
        glitch_val = 16'($urandom);
        @(posedge clk);
        for (int g = 0; g < 2; g++) model_edge(g, rdy[g]);
        @(negedge clk);
        for (int g = 0; g < 2; g++) check_regs(g);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        glitch = 2'b00;
        model_reset();
        #1;
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("rst_ready%0d", g), 32'(cmd_ready[g]), 32'(1'b0));
            check_regs(g);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int g = 0; g < 2; g++)
            check_eq($sformatf("post_rst_ready%0d", g), 32'(cmd_ready[g]), 32'(1'b1));
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (m_remain[0] == 0 && !m_hold[0] && m_remain[1] == 0 && !m_hold[1]) break;
            step();
        end
        check_eq("drain_idle", 32'(busy), 32'(2'b00));
    endtask

    task automatic send_one(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp, input bit ez, input bit en);
        bit fz, fn;
        fz = 1'b0;
        fn = 1'b0;
`ifdef LU_SEQ_FLAGS_EN
        fz = ez;
        fn = en;
`endif
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        step();
        cmd_valid = 1'b0;
        step();
        check_eq("one_valid", 32'(rsp_valid[0]), 32'(1'b1));
        check_eq("one_data", 32'(rsp_data[0]), 32'(exp));
        check_eq("one_zero", 32'(rsp_zero[0]), 32'(fz));
        check_eq("one_neg", 32'(rsp_neg[0]), 32'(fn));
        drain();
    endtask

    initial begin : main
        int lat;
        logic [15:0] hold_exp;
        #2;
        do_reset();

        // AND with default latency, counted once
        send_one(3'b000, 16'hFCC3, 16'hCFCC, 16'hCCC0, 1'b0, 1'b1);
        check_eq("and_count", 32'(op_count[0]), 32'd1);

        // OR then XOR chained with rsp_ready high
        do_reset();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_a = 16'hFCC3; cmd_b = 16'hCFCC;
        step();
        cmd_op = 3'b010;
        step();
        check_eq("or_data", 32'(rsp_data[0]), 32'h0000FFCF);
        step();
        check_eq("chain_valid", 32'(rsp_valid[0]), 32'(1'b1));
        cmd_valid = 1'b0;
        step();
        check_eq("xor_data", 32'(rsp_data[0]), 32'h0000330F);
        check_eq("xor_valid", 32'(rsp_valid[0]), 32'(1'b1));
        step();
        check_eq("chain_count", 32'(op_count[0]), 32'd2);
        drain();

        send_one(3'b111, 16'h0001, 16'h5555, 16'hFFFF, 1'b0, 1'b1);
        send_one(3'b110, 16'hFFFF, 16'h1234, 16'h0000, 1'b1, 1'b0);

        // Backpressure: result held, ready low, then same-cycle accept on release
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 16'h1234; cmd_b = 16'h00FF;
        step();
        cmd_a = 16'hABCD;
        step();
        hold_exp = lu_ref(3'b011, 16'h1234, 16'h00FF);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("bp_ready", 32'(cmd_ready[0]), 32'(1'b0));
            check_eq("bp_data", 32'(rsp_data[0]), 32'(hold_exp));
        end
        rsp_ready = 1'b1;
        step();
        check_eq("bp_accept", 32'(lu_a[0]), 32'h0000ABCD);
        drain();

        // Settle-3 latency
        cmd_valid = 1'b1; cmd_op = 3'b101; cmd_a = 16'h0F0F; cmd_b = 16'h00F0;
        step();
        cmd_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            lat++;
            if (rsp_valid[1]) break;
        end
        check_eq("lat3", 32'(lat), 32'd3);
        drain();

        // Reset in the middle of DRIVE on the settle-3 instance
        cmd_valid = 1'b1; cmd_op = 3'b100; cmd_a = 16'hAAAA; cmd_b = 16'hFFFF;
        step();
        cmd_valid = 1'b0;
        step();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("rst_no_rsp", 32'(rsp_valid[1]), 32'(1'b0));
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 9) < 7);
            cmd_op    = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       cmd_a = 16'h0000;
                1:       cmd_a = 16'hFFFF;
                default: cmd_a = 16'($urandom);
            endcase
            cmd_b = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            if ($urandom_range(0, 63) == 0) do_reset();
            else step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
